mips_multicycle_ctrl: RTL
=========================

# mips_multicycle_ctrl

Multicycle control unit for the MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the ALU's `alu_funct` and `alu_in_sel` inputs. It also drives the datapath write enables and the memory strobes, and consumes the ALU `zero_flag` to resolve `beq`. It sits directly upstream of the ALU and alongside the register file, PC and instruction register.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  instr[31:26] from the instruction register.
- `funct`  in  6  instr[5:0] from the instruction register.
- `zero_flag`  in  1  ALU zero output.
- `mem_ready`  in  1  memory access completes in the cycle this is high.
- `alu_funct`  out  2  to ALU: 2'b00 add, 2'b10 subtract.
- `alu_in_sel`  out  1  to ALU: 1 selects `sign_ext_imm`, 0 selects `reg_file_bus2`.
- `mem_read`  out  1  memory read strobe.
- `mem_write`  out  1  memory write strobe.
- `ir_write`  out  1  loads the instruction register.
- `pc_write`  out  1  loads the PC.
- `pc_src`  out  1  0 loads PC+4, 1 loads the branch target.
- `i_or_d`  out  1  memory address source: 0 PC, 1 ALU result register.
- `reg_write`  out  1  register-file write enable.
- `reg_dst`  out  1  write-address select: 1 rd, 0 rt.
- `mem_to_reg`  out  1  write-data select: 1 memory data register, 0 ALU result.
- `illegal_op`  out  1  one-cycle pulse on an undecodable instruction.
- `instr_count`  out  `CNT_W`  retired-instruction counter.

## Operation
- Supported instructions:
  - R-type: `opcode` 6'h00, with `funct` 6'h20 = add or 6'h22 = sub.
  - `lw` 6'h23, `sw` 6'h2B, `beq` 6'h04, `addi` 6'h08.
- States: IDLE, FETCH, DECODE, EX_R, EX_ADDR, EX_BEQ, EX_ADDI, MEM_RD, MEM_WR, WB_R, WB_LW, WB_I.
- Outputs are Moore: decoded from the state register only, except strobes qualified by `mem_ready` or `zero_flag` as noted below.
- Every output not listed for a state is 0.
- IDLE: all outputs 0; next state FETCH.
- FETCH: `mem_read`=1, `i_or_d`=0.
  - When `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=0; next state DECODE.
  - Otherwise hold in FETCH.
- DECODE: all outputs 0. Next state by opcode:
  - 6'h00 with valid funct → EX_R.
  - 6'h23 or 6'h2B → EX_ADDR.
  - 6'h04 → EX_BEQ.
  - 6'h08 → EX_ADDI.
  - Anything else, including R-type with any other funct: `illegal_op`=1 for that cycle, next state FETCH, counter unchanged.
- EX_R: `alu_in_sel`=0; `alu_funct`=2'b00 for funct 6'h20, 2'b10 for funct 6'h22. Next WB_R.
- EX_ADDR: `alu_in_sel`=1, `alu_funct`=2'b00. Next MEM_RD for `lw`, MEM_WR for `sw`.
- EX_ADDI: `alu_in_sel`=1, `alu_funct`=2'b00. Next WB_I.
- EX_BEQ: `alu_in_sel`=0, `alu_funct`=2'b10. `pc_src`=1 and `pc_write`=`zero_flag`. Next FETCH.
- MEM_RD: `mem_read`=1, `i_or_d`=1. On `mem_ready` go to WB_LW, else hold.
- MEM_WR: `mem_write`=1, `i_or_d`=1. On `mem_ready` go to FETCH, else hold.
- WB_R: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Next FETCH.
- WB_I: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Next FETCH.
- WB_LW: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1. Next FETCH.
- `instr_count` increments by 1 on the final cycle of each completed instruction:
  - WB_R, WB_I, WB_LW, EX_BEQ;
  - MEM_WR only when `mem_ready`=1.
- `instr_count` wraps from all-ones to 0 with no flag.

## Timing
- Reset (`reset_n`=0, asynchronous): state forced to IDLE, `instr_count`=0, all outputs 0 immediately. Reset mid-instruction abandons it; no partial writeback occurs.
- After `reset_n` deasserts, the first rising edge enters FETCH.
- Latency with `mem_ready` always 1, counted from entering FETCH:
  - `beq`: 3 cycles;
  - `sw`, R-type, `addi`: 4 cycles;
  - `lw`: 5 cycles;
  - illegal opcode: 2 cycles.
- Each low cycle of `mem_ready` in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- `mem_read` and `mem_write` are never high in the same cycle.
- `pc_write` is high at most once per FETCH visit and at most once per EX_BEQ visit.
- `zero_flag` is sampled only in EX_BEQ and is ignored in all other states.

## Test plan
- Reset: assert `reset_n`=0 mid-MEM_RD → outputs 0 and `instr_count`=0 within the same cycle. Release reset → IDLE then FETCH with `mem_read`=1.
- R-type sub: `opcode`=6'h00, `funct`=6'h22, `mem_ready`=1 → EX_R shows `alu_funct`=2'b10, `alu_in_sel`=0. Next cycle `reg_write`=1, `reg_dst`=1. `instr_count` goes 0→1 after 4 cycles.
- `lw` with memory stall: `opcode`=6'h23, `mem_ready` low for 2 cycles in MEM_RD → MEM_RD held 3 cycles, then WB_LW with `mem_to_reg`=1. Total 7 cycles.
- `beq`, both outcomes: `zero_flag`=1 → `pc_write`=1, `pc_src`=1 in EX_BEQ. `zero_flag`=0 → `pc_write`=0. Counter increments in both cases.
- Illegal op: `opcode`=6'h3F, and also `opcode`=6'h00 with `funct`=6'h24 → one-cycle `illegal_op` in DECODE, return to FETCH, no `reg_write`, counter unchanged.
- Counter wrap: `CNT_W`=4, run 16 `addi` instructions → `instr_count` reads 0 after the 16th.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives ALU selects, datapath write enables, memory strobes and a retire counter.
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero_flag,
    input  logic             mem_ready,
    output logic [1:0]       alu_funct,
    output logic             alu_in_sel,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             i_or_d,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EX_R, EX_ADDR, EX_BEQ, EX_ADDI,
        MEM_RD, MEM_WR, WB_R, WB_LW, WB_I
    } state_e;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;

    // State and retire counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        alu_funct  = 2'b00;
        alu_in_sel = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        i_or_d     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal_op = 1'b0;
        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                if (opcode == OP_R && (funct == FN_ADD || funct == FN_SUB))
                    state_d = EX_R;
                else if (opcode == OP_LW || opcode == OP_SW)
                    state_d = EX_ADDR;
                else if (opcode == OP_BEQ)
                    state_d = EX_BEQ;
                else if (opcode == OP_ADDI)
                    state_d = EX_ADDI;
                else begin
                    illegal_op = 1'b1;
                    state_d    = FETCH;
                end
            end
            EX_R: begin
                alu_funct = (funct == FN_SUB) ? 2'b10 : 2'b00;
                state_d   = WB_R;
            end
            EX_ADDR: begin
                alu_in_sel = 1'b1;
                state_d    = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            end
            EX_ADDI: begin
                alu_in_sel = 1'b1;
                state_d    = WB_I;
            end
            EX_BEQ: begin
                alu_funct = 2'b10;
                pc_src    = 1'b1;
                pc_write  = zero_flag;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_d = WB_LW;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            WB_I: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            WB_LW: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = FETCH;
            end
            default: state_d = IDLE;
        endcase
        cnt_d = retire ? cnt_q + 1'b1 : cnt_q;
    end

    assign instr_count = cnt_q;

endmodule
